decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
- Second stage of the 3-stage RV32I pipeline; consumer end of the fetch-to-decode interface.
- Takes InstrD/PCD/PCPlus4D from the fetch stage and decodes control signals.
- Reads the register file, which has write-first bypass from writeback, and extends the immediate.
- Registers everything into the D/E pipeline register. PCSrcE (execute-stage redirect) flushes that register.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-low
InstrD  in  32  instruction from fetch
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
PCSrcE  in  1  execute redirect; flushes D/E register
RegWriteW  in  1  writeback enable
RdW  in  5  writeback address
ResultW  in  32  writeback data
RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE  out  1 each  registered controls
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered operands/PCs
RdE, Rs1E, Rs2E  out  5 each  registered register indices

Behaviour:
- Reset: at posedge clk with rst=0, all outputs become 0 and registers x1..x31 clear to 0. Any writeback in that cycle is ignored.
- Latency: one cycle. Values decoded from InstrD at edge N appear on the E outputs after edge N.
- Opcode decode (all others illegal):
  - 0110011 R-type: RegWrite=1, ALUSrc=0.
  - 0010011 I-ALU: RegWrite=1, ALUSrc=1, imm I.
  - 0000011 lw: RegWrite=1, ALUSrc=1, ResultSrc=01, add, imm I.
  - 0100011 sw: MemWrite=1, ALUSrc=1, add, imm S.
  - 1100011 beq: Branch=1, sub, imm B.
  - 1101111 jal: RegWrite=1, Jump=1, ResultSrc=10, imm J.
- ALU field decode (R-type and I-ALU):
  - funct3 000: add, except R-type with funct7[5]=1 gives sub. I-type never gives sub.
  - funct3 010: slt. 110: or. 111: and. Other funct3 values: add.
- Illegal opcode: all control outputs 0 (bubble). Data fields are still captured. InstrD=0 therefore decodes as a bubble.
- Immediates, all sign-extended from bit 31:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R-type: ImmExt=0.
- Register file:
  - Two combinational read ports, one synchronous write port at posedge when RegWriteW=1 and RdW≠0.
  - Writes to x0 are discarded; reads of x0 return 0.
  - Write-first bypass: if RegWriteW=1, RdW≠0 and RdW equals Rs1/Rs2, the read returns ResultW in the same cycle.
- Flush: PCSrcE=1 at posedge loads the D/E register with all zeros. The register-file write in the same cycle still commits.
- Priority: rst=0 over PCSrcE=1 over normal capture.
- No stall input: the D/E register captures every cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - Opcode constants.
  - ALUControl encodings.
  - ResultSrc encodings.
  - ImmSrc encoding: I=00, S=01, B=10, J=11.
- One natural sub-module, register_file: 32x32, synchronous active-low clear, write-first bypass, x0 zero.
- Control decode and immediate extension stay inline as combinational logic.

Test Plan:
- Reset: hold rst=0 for 2 cycles with InstrD=0x00500093 → all outputs 0. Release → one cycle later RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- Write-first bypass: RegWriteW=1, RdW=3, ResultW=0xDEADBEEF, with InstrD=0x00318233 (add x4,x3,x3) in the same cycle → RD1E=RD2E=0xDEADBEEF. Also RdW=0 with ResultW=7, then read x0 → 0.
- Immediates: InstrD=0xFE000EE3 (beq, offset −4) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC. InstrD=0x008000EF (jal x1,8) → JumpE=1, ResultSrcE=10, ImmExtE=8, PCPlus4E=PCD+4.
- Load/store: InstrD=0xFFC12083 (lw x1,−4(x2)) → ResultSrcE=01, ImmExtE=0xFFFFFFFC. InstrD=0x00112423 (sw x1,8(x2)) → MemWriteE=1, RegWriteE=0, ImmExtE=8.
- Flush priority: PCSrcE=1 with valid add and RegWriteW=1/RdW=5/ResultW=9 → E outputs all 0 next cycle, x5 reads 9 afterwards. PCSrcE=1 with rst=0 → reset behaviour, x5 cleared.
- Illegal/sub decoding: InstrD=0x0000007F → all controls 0. 0x40208033 (sub) → ALUControlE=001. 0x40208013 (addi with imm bit 10 set) → ALUControlE=000, ImmExtE=0x402.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the D/E pipeline register payload.
// Holds opcode values, ALU/result/immediate select encodings and the
// packed struct carried from decode into execute.
package riscv_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned REG_AW = 5;

    // Base opcodes handled by this core; anything else is a bubble
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    // Everything the execute stage receives from decode
    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              branch;
        logic              jump;
        logic              alu_src;
        result_src_e       result_src;
        alu_ctrl_e         alu_ctrl;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } de_bus_t;

endpackage

// File: rtl/register_file.sv
// 32x32 architectural register file with x0 hardwired to zero.
// Ports:
//   clk, rst          clock and synchronous active-low clear of x1..x31
//   we, waddr, wdata  synchronous write port (writes to x0 dropped)
//   raddr1/2          combinational read addresses
//   rdata1_c/2_c      combinational read data, write-first bypassed
module register_file
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1_c,
    output logic [XLEN-1:0]   rdata2_c
);

    // x0 has no storage; only x1..x31 are flops
    logic [XLEN-1:0] mem_q [1:NREG-1];
    logic [XLEN-1:0] mem_d [1:NREG-1];
    logic            wr_en;

    assign wr_en = we && (waddr != REG_AW'(0));

    // Next-state of the array: at most one entry changes per cycle
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Write-first: a same-cycle writeback to the read address wins
    always_comb begin
        rdata1_c = '0;
        if (raddr1 != REG_AW'(0)) begin
            rdata1_c = (wr_en && (waddr == raddr1)) ? wdata : mem_q[raddr1];
        end
    end

    always_comb begin
        rdata2_c = '0;
        if (raddr2 != REG_AW'(0)) begin
            rdata2_c = (wr_en && (waddr == raddr2)) ? wdata : mem_q[raddr2];
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension
// and the D/E pipeline register.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   InstrD, PCD, PCPlus4D        instruction and PCs from fetch
//   PCSrcE                       execute redirect, zeroes the D/E register
//   RegWriteW, RdW, ResultW      writeback into the register file
//   *E outputs                   registered D/E pipeline contents
module decode_cycle
    import riscv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   InstrD,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic              PCSrcE,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [XLEN-1:0]   ResultW,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              JumpE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [REG_AW-1:0] RdE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              funct7_b5;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;

    assign opcode    = InstrD[6:0];
    assign funct3    = InstrD[14:12];
    assign funct7_b5 = InstrD[30];
    assign rs1       = InstrD[19:15];
    assign rs2       = InstrD[24:20];
    assign rd        = InstrD[11:7];

    logic [XLEN-1:0] rd1_c;
    logic [XLEN-1:0] rd2_c;

    register_file u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (RegWriteW),
        .waddr    (RdW),
        .wdata    (ResultW),
        .raddr1   (rs1),
        .raddr2   (rs2),
        .rdata1_c (rd1_c),
        .rdata2_c (rd2_c)
    );

    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
    imm_src_e    imm_src;
    logic        imm_used;
    logic        alu_from_funct;
    logic        is_rtype;

    // Main control decode; unknown opcodes leave every control at zero
    always_comb begin
        reg_write      = 1'b0;
        mem_write      = 1'b0;
        branch         = 1'b0;
        jump           = 1'b0;
        alu_src        = 1'b0;
        result_src     = RES_ALU;
        alu_ctrl       = ALU_ADD;
        imm_src        = IMM_I;
        imm_used       = 1'b0;
        alu_from_funct = 1'b0;
        is_rtype       = 1'b0;
        unique case (opcode)
            OP_R: begin
                reg_write      = 1'b1;
                alu_from_funct = 1'b1;
                is_rtype       = 1'b1;
            end
            OP_IALU: begin
                reg_write      = 1'b1;
                alu_src        = 1'b1;
                imm_used       = 1'b1;
                alu_from_funct = 1'b1;
            end
            OP_LW: begin
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = RES_MEM;
                imm_used   = 1'b1;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
                imm_used  = 1'b1;
            end
            OP_BEQ: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                imm_src  = IMM_B;
                imm_used = 1'b1;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                result_src = RES_PC4;
                imm_src    = IMM_J;
                imm_used   = 1'b1;
            end
            default: begin
            end
        endcase

        // funct3 selects the ALU op; only R-type honours funct7[5] as sub
        if (alu_from_funct) begin
            case (funct3)
                3'b000:  alu_ctrl = (is_rtype && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_ctrl = ALU_SLT;
                3'b110:  alu_ctrl = ALU_OR;
                3'b111:  alu_ctrl = ALU_AND;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

    logic [XLEN-1:0] imm_ext;

    // Sign-extended immediate; zero when the format carries none
    always_comb begin
        imm_ext = '0;
        if (imm_used) begin
            case (imm_src)
                IMM_I: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
                IMM_S: imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
                IMM_B: imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7],
                                  InstrD[30:25], InstrD[11:8], 1'b0};
                IMM_J: imm_ext = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12],
                                  InstrD[20], InstrD[30:21], 1'b0};
                default: imm_ext = '0;
            endcase
        end
    end

    de_bus_t de_q;
    de_bus_t de_d;

    // D/E register next value; a redirect squashes the whole entry
    always_comb begin
        de_d = '0;
        if (!PCSrcE) begin
            de_d.reg_write  = reg_write;
            de_d.mem_write  = mem_write;
            de_d.branch     = branch;
            de_d.jump       = jump;
            de_d.alu_src    = alu_src;
            de_d.result_src = result_src;
            de_d.alu_ctrl   = alu_ctrl;
            de_d.rd1        = rd1_c;
            de_d.rd2        = rd2_c;
            de_d.imm        = imm_ext;
            de_d.pc         = PCD;
            de_d.pc_plus4   = PCPlus4D;
            de_d.rd         = rd;
            de_d.rs1        = rs1;
            de_d.rs2        = rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    assign RegWriteE   = de_q.reg_write;
    assign MemWriteE   = de_q.mem_write;
    assign BranchE     = de_q.branch;
    assign JumpE       = de_q.jump;
    assign ALUSrcE     = de_q.alu_src;
    assign ResultSrcE  = de_q.result_src;
    assign ALUControlE = de_q.alu_ctrl;
    assign RD1E        = de_q.rd1;
    assign RD2E        = de_q.rd2;
    assign ImmExtE     = de_q.imm;
    assign PCE         = de_q.pc;
    assign PCPlus4E    = de_q.pc_plus4;
    assign RdE         = de_q.rd;
    assign Rs1E        = de_q.rs1;
    assign Rs2E        = de_q.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Scoreboard bench for decode_cycle: directed vectors followed by random
// instruction traffic, checked against an instruction-level reference model.
module tb_decode_cycle;

    logic        clk;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        PCSrcE, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE, Rs1E, Rs2E;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .PCSrcE(PCSrcE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
        .JumpE(JumpE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw, mw, br, jp, as;
        logic [1:0]  rs;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rd, rs1, rs2;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] regs [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Architectural register value seen by decode this cycle
    function automatic logic [31:0] rd_reg(input int r, input logic rw,
                                           input int rdw, input logic [31:0] resw);
        if (r == 0) return 32'h0;
        if (rw && rdw == r) return resw;
        return regs[r];
    endfunction

    // Instruction-level meaning of InstrD as execute should receive it
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] pc4, input logic rw,
                                   input int rdw, input logic [31:0] resw);
        exp_t e;
        int   f3, s;
        e     = '0;
        f3    = int'(ins[14:12]);
        s     = ins[31] ? -1 : 0;
        e.pc  = pc;
        e.pc4 = pc4;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd1 = rd_reg(int'(ins[19:15]), rw, rdw, resw);
        e.rd2 = rd_reg(int'(ins[24:20]), rw, rdw, resw);
        case (ins[6:0])
            7'b0110011, 7'b0010011: begin
                e.rw = 1'b1;
                e.as = (ins[6:0] == 7'b0010011);
                if (e.as) e.imm = 32'($signed(ins) >>> 20);
                case (f3)
                    0: e.alu = (!e.as && ins[30]) ? 3'd1 : 3'd0;
                    2: e.alu = 3'd5;
                    6: e.alu = 3'd3;
                    7: e.alu = 3'd2;
                    default: e.alu = 3'd0;
                endcase
            end
            7'b0000011: begin
                e.rw = 1'b1; e.as = 1'b1; e.rs = 2'd1;
                e.imm = 32'($signed(ins) >>> 20);
            end
            7'b0100011: begin
                e.mw = 1'b1; e.as = 1'b1;
                e.imm = 32'(s * 4096 + int'(ins[31:25]) * 32 + int'(ins[11:7]));
            end
            7'b1100011: begin
                e.br = 1'b1; e.alu = 3'd1;
                e.imm = 32'(s * 4096 + int'(ins[7]) * 2048
                            + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
            end
            7'b1101111: begin
                e.rw = 1'b1; e.jp = 1'b1; e.rs = 2'd2;
                e.imm = 32'(s * 1048576 + int'(ins[19:12]) * 4096
                            + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2);
            end
            default: begin
                e.rw = 1'b0;
            end
        endcase
        return e;
    endfunction

    // Drive one cycle, queue what the E outputs must show after the edge
    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic rs_n, input logic rw,
                         input logic [4:0] rdw, input logic [31:0] resw);
        exp_t e;
        @(negedge clk);
        InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; PCSrcE = fl; rst = rs_n;
        RegWriteW = rw; RdW = rdw; ResultW = resw;
        e = model(ins, pc, pc + 32'd4, rw && rdw != 5'd0, int'(rdw), resw);
        if (!rs_n || fl) e = '0;
        exp_q.push_back(e);
        if (!rs_n) begin
            for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        end else if (rw && rdw != 5'd0) begin
            regs[rdw] = resw;
        end
    endtask

    // Monitor: the D/E register presents a new entry after every edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("RegWriteE",   32'(RegWriteE),   32'(e.rw));
                chk("MemWriteE",   32'(MemWriteE),   32'(e.mw));
                chk("BranchE",     32'(BranchE),     32'(e.br));
                chk("JumpE",       32'(JumpE),       32'(e.jp));
                chk("ALUSrcE",     32'(ALUSrcE),     32'(e.as));
                chk("ResultSrcE",  32'(ResultSrcE),  32'(e.rs));
                chk("ALUControlE", 32'(ALUControlE), 32'(e.alu));
                chk("RD1E",        RD1E,             e.rd1);
                chk("RD2E",        RD2E,             e.rd2);
                chk("ImmExtE",     ImmExtE,          e.imm);
                chk("PCE",         PCE,              e.pc);
                chk("PCPlus4E",    PCPlus4E,         e.pc4);
                chk("RdE",         32'(RdE),         32'(e.rd));
                chk("Rs1E",        32'(Rs1E),        32'(e.rs1));
                chk("Rs2E",        32'(Rs2E),        32'(e.rs2));
            end
        end
    end

    initial begin
        logic [31:0] r, ins, pc;
        logic [6:0]  ops [7];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                7'b1100011, 7'b1101111, 7'b1111111};
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        rst = 1'b0; InstrD = '0; PCD = '0; PCPlus4D = '0; PCSrcE = 1'b0;
        RegWriteW = 1'b0; RdW = '0; ResultW = '0;

        // reset held two cycles, then addi x1,x0,5
        drive(32'h00500093, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(32'h00500093, 32'h100, 1'b0, 1'b0, 1'b1, 5'd4, 32'h55);
        drive(32'h00500093, 32'h100, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        // write-first bypass and x0
        drive(32'h00318233, 32'h104, 1'b0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF);
        drive(32'h00000333, 32'h108, 1'b0, 1'b1, 1'b1, 5'd0, 32'h7);
        drive(32'h00000333, 32'h10C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        drive(32'h00318233, 32'h110, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        // branch, jump, load, store immediates
        drive(32'hFE000EE3, 32'h114, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        drive(32'h008000EF, 32'h118, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        drive(32'hFFC12083, 32'h11C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        drive(32'h00112423, 32'h120, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        // flush keeps the writeback; reset beats flush and clears x5
        drive(32'h00528333, 32'h124, 1'b1, 1'b1, 1'b1, 5'd5, 32'h9);
        drive(32'h00528333, 32'h128, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        drive(32'h00528333, 32'h12C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(32'h00528333, 32'h130, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        // illegal opcode, sub, addi with bit 30 set
        drive(32'h0000007F, 32'h134, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        drive(32'h40208033, 32'h138, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        drive(32'h40208013, 32'h13C, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);

        // random traffic over legal and illegal opcodes
        for (int n = 0; n < 400; n++) begin
            r   = $urandom();
            ins = {r[31:7], ops[$urandom_range(0, 6)]};
            pc  = $urandom();
            drive(ins, pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 39) != 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
        end

        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
